// File: rtl/serv_vpu_pkg.sv
// Shared definitions for the SERV/VPU data-bus arbiter: grant-state encoding
// and the default watchdog width.
package serv_vpu_pkg;

  localparam int TIMEOUT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_CORE = 2'd1,
    ST_GNT_VPU  = 2'd2
  } state_t;

endpackage

// File: rtl/serv_vpu_dbus_arb_if.sv
// Signal bundle around the arbiter: core and VPU requester ports plus the shared
// Wishbone data-bus master. The arbiter takes the slave view.
interface serv_vpu_dbus_arb_if;
  logic        i_core_cyc, i_core_we;
  logic [31:0] i_core_adr, i_core_dat;
  logic [3:0]  i_core_sel;
  logic [31:0] o_core_rdt;
  logic        o_core_ack, o_core_err;

  logic        i_vpu_cyc, i_vpu_we;
  logic [31:0] i_vpu_adr, i_vpu_dat;
  logic [3:0]  i_vpu_sel;
  logic [31:0] o_vpu_rdt;
  logic        o_vpu_ack, o_vpu_err;

  logic        o_wb_cyc, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_grant_vpu;

  modport slave (
    input  i_core_cyc, i_core_we, i_core_adr, i_core_dat, i_core_sel,
    input  i_vpu_cyc, i_vpu_we, i_vpu_adr, i_vpu_dat, i_vpu_sel,
    input  i_wb_rdt, i_wb_ack,
    output o_core_rdt, o_core_ack, o_core_err,
    output o_vpu_rdt, o_vpu_ack, o_vpu_err,
    output o_wb_cyc, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    output o_grant_vpu
  );

  modport master (
    output i_core_cyc, i_core_we, i_core_adr, i_core_dat, i_core_sel,
    output i_vpu_cyc, i_vpu_we, i_vpu_adr, i_vpu_dat, i_vpu_sel,
    output i_wb_rdt, i_wb_ack,
    input  o_core_rdt, o_core_ack, o_core_err,
    input  o_vpu_rdt, o_vpu_ack, o_vpu_err,
    input  o_wb_cyc, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    input  o_grant_vpu
  );
endinterface

// File: rtl/serv_vpu_dbus_wdt.sv
// Bus watchdog: counts un-acked grant cycles; o_hit flags the cycle that is the
// (2^W-1)-th one, so a timeout can be taken on that same cycle.
module serv_vpu_dbus_wdt #(
  parameter int W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  // cnt holds the number of earlier un-acked cycles, hence the limit minus one
  localparam logic [W-1:0] LAST = {W{1'b1}} - 1'b1;

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + 1'b1;
  end

  assign o_hit = (cnt == LAST);
endmodule

// File: rtl/serv_vpu_dbus_arb.sv
// Round-robin arbiter sharing one Wishbone data bus between the SERV core and
// the VPU load/store unit, with a per-transaction watchdog.
module serv_vpu_dbus_arb
  import serv_vpu_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter bit WITH_ERR  = 1'b1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  serv_vpu_dbus_arb_if.slave bus
);
  state_t state, state_nxt;
  logic   last_vpu;
  logic   req_cyc, wdt_hit, timeout;
  logic   core_err_q, vpu_err_q;

  assign req_cyc = (state == ST_GNT_CORE) ? bus.i_core_cyc :
                   (state == ST_GNT_VPU)  ? bus.i_vpu_cyc  : 1'b0;
  // an ack landing on the limit cycle wins over the timeout
  assign timeout = WITH_ERR && wdt_hit && req_cyc && !bus.i_wb_ack;

  serv_vpu_dbus_wdt #(.W(TIMEOUT_W)) u_wdt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state == ST_IDLE),
    .i_en    ((state != ST_IDLE) && !bus.i_wb_ack),
    .o_hit   (wdt_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      last_vpu   <= 1'b1;
      core_err_q <= 1'b0;
      vpu_err_q  <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (state != ST_IDLE && state_nxt == ST_IDLE)
        last_vpu <= (state == ST_GNT_VPU);
      core_err_q <= timeout && (state == ST_GNT_CORE);
      vpu_err_q  <= timeout && (state == ST_GNT_VPU);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.i_core_cyc && bus.i_vpu_cyc)
          state_nxt = last_vpu ? ST_GNT_CORE : ST_GNT_VPU;
        else if (bus.i_core_cyc)
          state_nxt = ST_GNT_CORE;
        else if (bus.i_vpu_cyc)
          state_nxt = ST_GNT_VPU;
      end
      ST_GNT_CORE, ST_GNT_VPU: begin
        if (!req_cyc || bus.i_wb_ack || timeout)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_wb_cyc = 1'b0;
    bus.o_wb_we  = 1'b0;
    bus.o_wb_adr = '0;
    bus.o_wb_dat = '0;
    bus.o_wb_sel = '0;
    unique case (state)
      ST_GNT_CORE: begin
        bus.o_wb_cyc = bus.i_core_cyc;
        bus.o_wb_we  = bus.i_core_we;
        bus.o_wb_adr = bus.i_core_adr;
        bus.o_wb_dat = bus.i_core_dat;
        bus.o_wb_sel = bus.i_core_sel;
      end
      ST_GNT_VPU: begin
        bus.o_wb_cyc = bus.i_vpu_cyc;
        bus.o_wb_we  = bus.i_vpu_we;
        bus.o_wb_adr = bus.i_vpu_adr;
        bus.o_wb_dat = bus.i_vpu_dat;
        bus.o_wb_sel = bus.i_vpu_sel;
      end
      default: ;
    endcase
  end

  assign bus.o_core_rdt  = bus.i_wb_rdt;
  assign bus.o_vpu_rdt   = bus.i_wb_rdt;
  assign bus.o_core_ack  = bus.i_wb_ack && (state == ST_GNT_CORE);
  assign bus.o_vpu_ack   = bus.i_wb_ack && (state == ST_GNT_VPU);
  assign bus.o_core_err  = core_err_q;
  assign bus.o_vpu_err   = vpu_err_q;
  assign bus.o_grant_vpu = (state == ST_GNT_VPU);
endmodule

// File: doc/serv_vpu_dbus_arb.md
SERV_VPU_DBUS_ARB -- requirements
Module: serv_vpu_dbus_arb

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 8, the width of the watchdog counter; the timeout limit is 2^TIMEOUT_W-1 cycles.
REQ-002 The block SHALL have parameter WITH_ERR, default 1; when 1 a watchdog timeout raises an error, when 0 it never does.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_core_cyc / i_core_we  in  1 / 1  core data request valid / write.
REQ-006 i_core_adr / i_core_dat / i_core_sel  in  32 / 32 / 4  core address, write data, byte selects.
REQ-007 o_core_rdt / o_core_ack / o_core_err  out  32 / 1 / 1  core read data, ack, timeout error.
REQ-008 i_vpu_cyc, i_vpu_we, i_vpu_adr, i_vpu_dat, i_vpu_sel, o_vpu_rdt, o_vpu_ack, o_vpu_err  same widths and meaning as the core port, for the VPU load/store unit.
REQ-009 o_wb_cyc, o_wb_we, o_wb_adr[31:0], o_wb_dat[31:0], o_wb_sel[3:0]  out  shared Wishbone data-bus master.
REQ-010 i_wb_rdt / i_wb_ack  in  32 / 1  shared bus read data / acknowledge.
REQ-011 o_grant_vpu  out  1  high while the VPU owns the bus.

Function
REQ-012 States SHALL be IDLE, GNT_CORE and GNT_VPU.
REQ-013 IDLE, one requester active: next state is its GNT state.
REQ-014 IDLE, both requesters active: round-robin; the requester not granted last wins.
REQ-015 GNT_x: o_wb_cyc = i_x_cyc; o_wb_we/adr/dat/sel mux from requester x; in IDLE all o_wb_* are 0.
REQ-016 Latency SHALL be: request seen in IDLE at edge N gives o_wb_cyc high in the cycle after N; no combinational path from i_*_cyc to o_wb_cyc while in IDLE.
REQ-017 o_x_ack = i_wb_ack and state==GNT_x; the other port's ack is 0.
REQ-018 o_core_rdt and o_vpu_rdt SHALL both equal i_wb_rdt at all times; requesters qualify it with their ack.
REQ-019 On i_wb_ack in GNT_x the next state SHALL be IDLE, giving one idle cycle between back-to-back transactions; last-grant is updated to x.
REQ-020 If i_x_cyc drops in GNT_x before ack: next state IDLE, no ack or err to x, last-grant updated to x.
REQ-021 The watchdog SHALL be cleared in IDLE and increment each GNT cycle without ack.
REQ-022 On watchdog reaching the limit with WITH_ERR=1 and no ack in that cycle: o_x_err pulses high for exactly one cycle (registered, the cycle after); next state IDLE; o_wb_cyc low from the next cycle.
REQ-023 i_wb_ack in the same cycle as the watchdog limit SHALL be treated as a normal ack; no err.
REQ-024 i_wb_ack while IDLE SHALL be ignored; no ack is routed to either port.
REQ-025 o_grant_vpu = (state==GNT_VPU).

Reset
REQ-026 While i_rst_n is low: state IDLE, last-grant = VPU (core wins the first tie), watchdog 0, o_*_err 0.
REQ-027 Reset mid-transaction SHALL deassert o_wb_cyc, o_*_ack and o_grant_vpu immediately (asynchronously); no ack is delivered.
REQ-028 After release of i_rst_n, the first grant decision SHALL occur on the first rising edge.

Structure
REQ-029 The state encoding (2-bit) and the default TIMEOUT_W SHALL live in the shared package serv_vpu_pkg.
REQ-030 The watchdog SHALL be one sub-module, serv_vpu_dbus_wdt (clear, count enable, limit-reached output); the rest is flat.

Verification
REQ-031 Core-only read: i_core_cyc=1, adr 0x100; wb acks after 3 cycles with rdt 0xDEADBEEF -> o_wb_cyc high cycles 1-3; o_core_ack for 1 cycle; o_core_rdt = 0xDEADBEEF; o_vpu_ack stays 0.
REQ-032 Simultaneous requests from reset -> core granted first; after core ack, 1 idle cycle, then VPU granted; with both held active, grants alternate C,V,C,V.
REQ-033 TIMEOUT_W=3, VPU write, never acked -> o_vpu_err pulses once after 7 GNT cycles; state returns to IDLE; no ack on either port.
REQ-034 Ack arrives on the 7th cycle with TIMEOUT_W=3 -> normal o_*_ack; o_*_err stays 0.
REQ-035 Core drops i_core_cyc mid-transaction -> IDLE next cycle; pending VPU request granted the cycle after that.
REQ-036 i_rst_n pulsed low during GNT_VPU -> o_wb_cyc and o_grant_vpu fall without a clock edge; after release, the next tie grants the core.
